// File: rtl/acc_cpu_run_sequencer_pkg.sv
// acc_cpu_pkg: shared widths, opcodes and sequencer state encoding for the accumulator CPU host side
package acc_cpu_pkg;
    localparam int INSTR_W = 12;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_HALT = 4'b1010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } seq_state_e;
endpackage

// File: rtl/acc_cpu_run_sequencer_if.sv
// acc_cpu_run_sequencer_if: valid/ready program-load port from the host
interface acc_cpu_run_sequencer_if;
    logic ld_valid;
    logic ld_ready;
    logic ld_last;
    logic [acc_cpu_pkg::INSTR_W-1:0] ld_data;

    modport master (output ld_valid, ld_data, ld_last, input ld_ready);
    modport slave (input ld_valid, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/acc_cpu_run_sequencer_optable.sv
// acc_shadow_optable: 16x4 shadow copy of loaded opcodes, async read by CPU pc
module acc_shadow_optable
    import acc_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [3:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [3:0]        rdata
);
    logic [3:0] mem [DEPTH];

    // a write in the clearing cycle lands after the clear
    always_ff @(posedge clk) begin
        if (reset || clr)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        if (we && !reset)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/acc_cpu_run_sequencer.sv
// acc_cpu_run_sequencer: loads a program into the CPU, runs it, detects HALT/overrun/watchdog, captures AC
module acc_cpu_run_sequencer
    import acc_cpu_pkg::*;
#(
    parameter int         MAX_CYCLES = 64,
    parameter logic [3:0] HALT_OP    = OP_HALT
) (
    input  logic               clk,
    input  logic               reset,
    acc_cpu_run_sequencer_if.slave ld,
    input  logic               start,
    input  logic               abort,
    output logic               cpu_reset,
    output logic               cpu_we,
    output logic [ADDR_W-1:0]  cpu_instr_addr,
    output logic [INSTR_W-1:0] cpu_instr_in,
    input  logic [DATA_W-1:0]  cpu_ac,
    input  logic [ADDR_W-1:0]  cpu_pc,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic               timeout,
    output logic               overrun,
    output logic [ADDR_W:0]    prog_len
);
    seq_state_e state, state_n;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, wp;
    logic [7:0] cycle_cnt, cycle_cnt_n;
    logic [ADDR_W:0] prog_len_n;
    logic [ADDR_W-1:0] addr_n;
    logic [INSTR_W-1:0] instr_n;
    logic [DATA_W-1:0] result_n;
    logic ld_ready_q, ld_ready_n;
    logic we_n, timeout_n, overrun_n, cpu_reset_n, busy_n, done_n;
    logic hs, fresh, final_beat, last_taken, tab_clr, tab_we;
    logic halt_hit, overrun_hit, wd_hit;
    logic [3:0] shadow_op;

    acc_shadow_optable u_optable (
        .clk   (clk),
        .reset (reset),
        .clr   (tab_clr),
        .we    (tab_we),
        .waddr (wp),
        .wdata (ld.ld_data[INSTR_W-1:INSTR_W-4]),
        .raddr (cpu_pc),
        .rdata (shadow_op)
    );

    assign ld.ld_ready = ld_ready_q;
    assign hs          = ld.ld_valid && ld_ready_q;
    assign fresh       = state inside {S_IDLE, S_ARMED, S_DONE};
    assign wp          = fresh ? '0 : wr_ptr;
    assign final_beat  = ld.ld_last || (wp == ADDR_W'(DEPTH - 1));
    assign halt_hit    = shadow_op == HALT_OP;
    assign overrun_hit = {1'b0, cpu_pc} >= prog_len;
    assign wd_hit      = cycle_cnt == 8'(MAX_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            cycle_cnt      <= '0;
            prog_len       <= '0;
            cpu_we         <= 1'b0;
            cpu_instr_addr <= '0;
            cpu_instr_in   <= '0;
            ld_ready_q     <= 1'b0;
            cpu_reset      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            result         <= '0;
            timeout        <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state          <= state_n;
            wr_ptr         <= wr_ptr_n;
            cycle_cnt      <= cycle_cnt_n;
            prog_len       <= prog_len_n;
            cpu_we         <= we_n;
            cpu_instr_addr <= addr_n;
            cpu_instr_in   <= instr_n;
            ld_ready_q     <= ld_ready_n;
            cpu_reset      <= cpu_reset_n;
            busy           <= busy_n;
            done           <= done_n;
            result         <= result_n;
            timeout        <= timeout_n;
            overrun        <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        wr_ptr_n    = wr_ptr;
        cycle_cnt_n = '0;
        prog_len_n  = prog_len;
        we_n        = 1'b0;
        addr_n      = cpu_instr_addr;
        instr_n     = cpu_instr_in;
        result_n    = result;
        timeout_n   = timeout;
        overrun_n   = overrun;
        last_taken  = 1'b0;
        tab_clr     = 1'b0;
        tab_we      = 1'b0;
        if (abort) begin
            state_n    = S_IDLE;
            wr_ptr_n   = '0;
            prog_len_n = '0;
            timeout_n  = 1'b0;
            overrun_n  = 1'b0;
        end else if (hs) begin
            tab_clr    = fresh;
            tab_we     = 1'b1;
            we_n       = 1'b1;
            addr_n     = wp;
            instr_n    = ld.ld_data;
            wr_ptr_n   = wp + 1'b1;
            timeout_n  = 1'b0;
            overrun_n  = 1'b0;
            last_taken = final_beat;
            prog_len_n = final_beat ? {1'b0, wp} + 1'b1 : (fresh ? '0 : prog_len);
            state_n    = final_beat ? S_ARMED : S_LOAD;
        end else begin
            case (state)
                S_ARMED, S_DONE: if (start) begin
                    state_n   = S_RUN;
                    timeout_n = 1'b0;
                    overrun_n = 1'b0;
                end
                S_RUN: begin
                    cycle_cnt_n = cycle_cnt + 1'b1;
                    if (halt_hit) begin
                        state_n = S_CAPTURE;
                    end else if (overrun_hit) begin
                        state_n   = S_DONE;
                        overrun_n = 1'b1;
                        result_n  = cpu_ac;
                    end else if (wd_hit) begin
                        state_n   = S_DONE;
                        timeout_n = 1'b1;
                        result_n  = cpu_ac;
                    end
                end
                S_CAPTURE: begin
                    state_n  = S_DONE;
                    result_n = cpu_ac;
                end
                default: ;
            endcase
        end
        // ld_ready drops for one cycle after the closing beat
        ld_ready_n  = !last_taken && (state_n inside {S_IDLE, S_LOAD, S_ARMED, S_DONE});
        cpu_reset_n = !(state_n inside {S_RUN, S_CAPTURE});
        busy_n      = state_n inside {S_LOAD, S_RUN, S_CAPTURE};
        done_n      = state_n == S_DONE;
    end
endmodule

// File: tb/tb_acc_cpu_run_sequencer.sv
// tb_acc_cpu_run_sequencer: directed checks of load/run/capture with a behavioural accumulator CPU
module tb_acc_cpu_run_sequencer;
    import acc_cpu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic cpu_reset, cpu_we, busy, done, timeout, overrun;
    logic [3:0] cpu_instr_addr, cpu_pc;
    logic [11:0] cpu_instr_in;
    logic [7:0] cpu_ac, result;
    logic [4:0] prog_len;
    int total = 0;
    int passed = 0;
    int n;

    acc_cpu_run_sequencer_if ld ();

    acc_cpu_run_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .ld             (ld),
        .start          (start),
        .abort          (abort),
        .cpu_reset      (cpu_reset),
        .cpu_we         (cpu_we),
        .cpu_instr_addr (cpu_instr_addr),
        .cpu_instr_in   (cpu_instr_in),
        .cpu_ac         (cpu_ac),
        .cpu_pc         (cpu_pc),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .timeout        (timeout),
        .overrun        (overrun),
        .prog_len       (prog_len)
    );

    always #5 clk = ~clk;

    // accumulator CPU: HALT holds pc, unknown opcodes are no-ops
    logic [11:0] imem [16];
    logic [11:0] ins;
    assign ins = imem[cpu_pc];
    always @(posedge clk) begin
        if (cpu_we) imem[cpu_instr_addr] <= cpu_instr_in;
        if (cpu_reset) begin
            cpu_pc <= '0;
            cpu_ac <= '0;
        end else begin
            case (ins[11:8])
                OP_LOAD: cpu_ac <= ins[7:0];
                OP_ADD:  cpu_ac <= cpu_ac + ins[7:0];
                OP_SUB:  cpu_ac <= cpu_ac - ins[7:0];
                default: ;
            endcase
            if (ins[11:8] != OP_HALT) cpu_pc <= cpu_pc + 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_beat(input logic [11:0] d, input logic last, input logic [3:0] a);
        for (int i = 0; i < 20 && ld.ld_ready !== 1'b1; i++) tick();
        chk("beat_ready", 32'(ld.ld_ready), 1);
        ld.ld_valid = 1'b1;
        ld.ld_data = d;
        ld.ld_last = last;
        tick();
        ld.ld_valid = 1'b0;
        ld.ld_last = 1'b0;
        chk("cpu_we", 32'(cpu_we), 1);
        chk("waddr", 32'(cpu_instr_addr), 32'(a));
        chk("wdata", 32'(cpu_instr_in), 32'(d));
    endtask

    task automatic run(input int budget, output int cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_released", 32'(cpu_reset), 0);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("run_done", 32'(done), 1);
        chk("run_cpu_reset", 32'(cpu_reset), 1);
    endtask

    initial begin
        ld.ld_valid = 1'b0;
        ld.ld_last = 1'b0;
        ld.ld_data = '0;
        tick();
        tick();
        chk("rst_cpu_reset", 32'(cpu_reset), 1);
        chk("rst_we", 32'(cpu_we), 0);
        chk("rst_addr", 32'(cpu_instr_addr), 0);
        chk("rst_instr", 32'(cpu_instr_in), 0);
        chk("rst_ready", 32'(ld.ld_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", {timeout, overrun}, 0);
        chk("rst_len", 32'(prog_len), 0);
        reset = 1'b0;
        tick();
        chk("idle_ready", 32'(ld.ld_ready), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_start_ign", {busy, cpu_reset}, 2'b01);

        send_beat(12'h103, 1'b0, 4'd0);
        chk("t1_busy", 32'(busy), 1);
        send_beat(12'h205, 1'b0, 4'd1);
        send_beat(12'h302, 1'b0, 4'd2);
        send_beat(12'hA00, 1'b1, 4'd3);
        chk("t1_len", 32'(prog_len), 4);
        chk("t1_ready_drop", 32'(ld.ld_ready), 0);
        tick();
        chk("t1_armed", {ld.ld_ready, busy, cpu_we}, 3'b100);
        run(20, n);
        chk("t1_result", 32'(result), 6);
        chk("t1_flags", {timeout, overrun}, 0);

        send_beat(12'hA00, 1'b1, 4'd0);
        chk("t2_len", 32'(prog_len), 1);
        chk("t2_done_clr", 32'(done), 0);
        run(3, n);
        chk("t2_latency", 32'(n <= 3), 1);
        chk("t2_result", 32'(result), 0);

        for (int i = 0; i < 16; i++) send_beat(12'h201, 1'b0, 4'(i));
        chk("t3_len", 32'(prog_len), 16);
        chk("t3_ready_drop", 32'(ld.ld_ready), 0);
        ld.ld_valid = 1'b1;
        tick();
        ld.ld_valid = 1'b0;
        chk("t3_no_17th", 32'(cpu_we), 0);
        chk("t3_len_hold", 32'(prog_len), 16);
        run(100, n);
        chk("t3_timeout", {timeout, overrun}, 2'b10);
        chk("t3_result", 32'(result), 63);

        send_beat(12'h107, 1'b0, 4'd0);
        send_beat(12'h201, 1'b1, 4'd1);
        chk("t4_len", 32'(prog_len), 2);
        run(20, n);
        chk("t4_overrun", {timeout, overrun}, 2'b01);
        chk("t4_result", 32'(result), 8);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", {done, timeout, overrun}, 0);
        chk("abort_idle", {busy, cpu_reset, ld.ld_ready}, 3'b011);
        send_beat(12'h1AA, 1'b0, 4'd0);
        send_beat(12'h2BB, 1'b0, 4'd1);
        abort = 1'b1;
        ld.ld_valid = 1'b1;
        ld.ld_data = 12'h3CC;
        tick();
        abort = 1'b0;
        ld.ld_valid = 1'b0;
        chk("t5_len", 32'(prog_len), 0);
        chk("t5_idle", {busy, cpu_we, cpu_reset}, 3'b001);
        send_beat(12'h109, 1'b0, 4'd0);
        send_beat(12'hA00, 1'b1, 4'd1);
        chk("t5_len2", 32'(prog_len), 2);
        run(20, n);
        chk("t5_result", 32'(result), 9);
        chk("t5_flags", {timeout, overrun}, 0);

        start = 1'b1;
        ld.ld_valid = 1'b1;
        ld.ld_data = 12'h301;
        tick();
        start = 1'b0;
        ld.ld_valid = 1'b0;
        chk("t6_load_wins", {busy, done, cpu_reset, cpu_we}, 4'b1011);
        chk("t6_addr", 32'(cpu_instr_addr), 0);
        tick();
        chk("t6_no_run", 32'(cpu_reset), 1);
        send_beat(12'hA00, 1'b1, 4'd1);
        chk("t6_len", 32'(prog_len), 2);
        run(20, n);
        chk("t6_result", 32'(result), 8'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
